// File: rtl/barrel_shifter_pipe.sv
// ============================================================================
// Module   : barrel_shifter_pipe
// Purpose  : Two-stage valid/ready pipelined barrel shifter (rotate right/left,
//            logical and arithmetic shift right). Optional 16-bit output
//            transfer counter enabled by macro BSHIFT_XFER_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module barrel_shifter_pipe #(
  parameter int WIDTH = 8,
  parameter int AMTW  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AMTW-1:0]  in_amt,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef BSHIFT_XFER_CNT_EN
  ,
  output logic [15:0]      xfer_cnt
`endif
);

  localparam logic [1:0] c_MODE_ROR = 2'b00;
  localparam logic [1:0] c_MODE_ROL = 2'b01;
  localparam logic [1:0] c_MODE_LSR = 2'b10;
  localparam logic [1:0] c_MODE_ASR = 2'b11;

  logic             r_v1;
  logic [WIDTH-1:0] r_data;
  logic [AMTW-1:0]  r_amt;
  logic [1:0]       r_mode;
  logic             r_v2;
  logic [WIDTH-1:0] r_res;

  logic               w_adv2;
  logic [2*WIDTH-1:0] w_dbl;
  logic [2*WIDTH-1:0] w_ror_full;
  logic [2*WIDTH-1:0] w_rol_full;
  logic [WIDTH-1:0]   w_lsr;
  logic [WIDTH-1:0]   w_asr;
  logic [WIDTH-1:0]   w_shift;

  assign w_adv2   = ~r_v2 | out_ready;
  assign in_ready = ~r_v1 | w_adv2;

  // Rotates come from shifting a doubled copy of the operand.
  assign w_dbl      = {r_data, r_data};
  assign w_ror_full = w_dbl >> r_amt;
  assign w_rol_full = w_dbl << r_amt;
  assign w_lsr      = r_data >> r_amt;
  assign w_asr      = $unsigned($signed(r_data) >>> r_amt);

  always_comb begin
    w_shift = r_data;
    case (r_mode)
      c_MODE_ROR: w_shift = w_ror_full[WIDTH-1:0];
      c_MODE_ROL: w_shift = w_rol_full[2*WIDTH-1:WIDTH];
      c_MODE_LSR: w_shift = w_lsr;
      c_MODE_ASR: w_shift = w_asr;
      default:    w_shift = r_data;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1   <= 1'b0;
      r_data <= '0;
      r_amt  <= '0;
      r_mode <= '0;
      r_v2   <= 1'b0;
      r_res  <= '0;
    end else begin
      if (in_ready) begin
        r_v1   <= in_valid;
        r_data <= in_data;
        r_amt  <= in_amt;
        r_mode <= in_mode;
      end
      if (w_adv2) begin
        r_v2 <= r_v1;
      end
      if (w_adv2 && r_v1) begin
        r_res <= w_shift;
      end
    end
  end

  assign out_valid = r_v2;
  assign out_data  = r_res;

`ifdef BSHIFT_XFER_CNT_EN
  logic [15:0] r_xfer_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_xfer_cnt <= 16'h0000;
    end else if (r_v2 && out_ready) begin
      r_xfer_cnt <= r_xfer_cnt + 16'h0001;
    end
  end

  assign xfer_cnt = r_xfer_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_barrel_shifter_pipe.sv
// ============================================================================
// Module   : tb_barrel_shifter_pipe
// Purpose  : Scoreboard bench for barrel_shifter_pipe (WIDTH=8) with directed
//            vectors; counter wrap exercised when BSHIFT_XFER_CNT_EN is set.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_barrel_shifter_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [2:0] in_amt;
  logic [1:0] in_mode;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
`ifdef BSHIFT_XFER_CNT_EN
  logic [15:0] xfer_cnt;
`endif

  barrel_shifter_pipe #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amt    (in_amt),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef BSHIFT_XFER_CNT_EN
    ,
    .xfer_cnt  (xfer_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] exp;
    int         cyc;
    bit         chk_lat;
  } sb_t;

  sb_t sb_q[$];
  int  cyc = 0;
  int  n_chk = 0;
  int  n_pass = 0;
  bit  lat_chk_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: a transfer seen at the negedge completes on the next posedge.
  logic       r_stall_prev = 1'b0;
  logic [7:0] r_data_prev  = 8'h00;
  always @(negedge clk) begin
    if (!rst) begin
      if (r_stall_prev) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, r_data_prev);
      end
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_out", out_data, 8'hxx === 8'hxx ? -1 : 0);
        end else begin
          sb_t e;
          e = sb_q.pop_front();
          chk("out_data", out_data, e.exp);
          if (e.chk_lat) chk("latency", cyc - e.cyc, 2);
        end
      end
      r_stall_prev = out_valid && !out_ready;
      r_data_prev  = out_data;
    end else begin
      r_stall_prev = 1'b0;
    end
  end

  // Offers one operand and returns the number of cycles it waited for in_ready.
  task automatic send(input logic [7:0] d, input logic [2:0] a, input logic [1:0] m,
                      input logic [7:0] exp, output int stalls);
    sb_t e;
    stalls = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_amt   = a;
    in_mode  = m;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        e.exp = exp;
        e.cyc = cyc;
        e.chk_lat = lat_chk_en;
        sb_q.push_back(e);
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
      stalls++;
      if (stalls > 50) begin
        chk("send_timeout", stalls, 0);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (sb_q.size() != 0 && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    chk("drain_empty", sb_q.size(), 0);
  endtask

  typedef struct {
    logic [7:0] d;
    logic [2:0] a;
    logic [1:0] m;
    logic [7:0] exp;
  } vec_t;

  vec_t v_basic[8] = '{
    '{8'hB1, 3'd3, 2'b00, 8'h36},
    '{8'hB1, 3'd3, 2'b01, 8'h8D},
    '{8'hB1, 3'd3, 2'b10, 8'h16},
    '{8'hB1, 3'd3, 2'b11, 8'hF6},
    '{8'h5A, 3'd0, 2'b00, 8'h5A},
    '{8'h5A, 3'd0, 2'b01, 8'h5A},
    '{8'h5A, 3'd0, 2'b10, 8'h5A},
    '{8'h5A, 3'd0, 2'b11, 8'h5A}
  };

  initial begin
    int st;
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_amt = 3'd0; in_mode = 2'b00;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk); #1;

    // Four modes on 0xB1/amt 3, then amt 0 on 0x5A; no backpressure.
    lat_chk_en = 1'b1;
    foreach (v_basic[i]) begin
      send(v_basic[i].d, v_basic[i].a, v_basic[i].m, v_basic[i].exp, st);
      chk("basic_stall", st, 0);
    end
    drain();

    // Back-to-back rotate-left stream.
    send(8'h01, 3'd1, 2'b01, 8'h02, st); chk("b2b_ready0", st, 0);
    send(8'h02, 3'd1, 2'b01, 8'h04, st); chk("b2b_ready1", st, 0);
    send(8'h03, 3'd1, 2'b01, 8'h06, st); chk("b2b_ready2", st, 0);
    drain();
    lat_chk_en = 1'b0;

    // Backpressure: two operands fill the pipe, the third must wait.
    out_ready = 1'b0;
    send(8'hF0, 3'd4, 2'b10, 8'h0F, st);
    send(8'h84, 3'd2, 2'b11, 8'hE1, st);
    in_valid = 1'b1; in_data = 8'h03; in_amt = 3'd1; in_mode = 2'b00;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
      @(posedge clk); #1;
    end
    chk("bp_accepted", sb_q.size(), 2);
    out_ready = 1'b1;
    send(8'h03, 3'd1, 2'b00, 8'h81, st);
    drain();

    // Reset with both stages full: in-flight results must vanish.
    out_ready = 1'b0;
    send(8'hAA, 3'd1, 2'b00, 8'h55, st);
    send(8'hAA, 3'd2, 2'b00, 8'hAA, st);
    @(posedge clk); #1;
    rst = 1'b1; in_valid = 1'b1; in_data = 8'hFF; in_amt = 3'd1; in_mode = 2'b10;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    sb_q.delete();
    @(negedge clk);
    chk("rst_mid_out_valid", out_valid, 0);
    chk("rst_mid_in_ready", in_ready, 1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    send(8'h80, 3'd7, 2'b11, 8'hFF, st);
    send(8'h81, 3'd7, 2'b01, 8'hC0, st);
    drain();

`ifdef BSHIFT_XFER_CNT_EN
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    in_valid = 1'b1; in_data = 8'h00; in_amt = 3'd0; in_mode = 2'b00;
    for (int k = 0; k < 65535; k++) begin
      sb_t e;
      e.exp = 8'h00; e.cyc = 0; e.chk_lat = 1'b0;
      sb_q.push_back(e);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    out_ready = 1'b0;
    #1;
    @(negedge clk);
    chk("cnt_preload", xfer_cnt, 16'hFFFF);
    out_ready = 1'b1;
    send(8'h00, 3'd0, 2'b00, 8'h00, st);
    drain();
    @(negedge clk);
    chk("cnt_wrap", xfer_cnt, 16'h0000);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
